// File: rtl/util_fifo_pkg.sv
// Shared FIFO helpers: lane-order constants
// and a constant-foldable clog2.
package util_fifo_pkg;

  localparam int LANE_LSB_FIRST = 0;
  localparam int LANE_MSB_FIRST = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/util_wconv_fifo_if.sv
// Write/read bundle of the width-converting FIFO.
// master drives requests, slave returns data and flags.
interface util_wconv_fifo_if #(
  parameter int DOUT_W = 32,
  parameter int RATIO  = 4
);

  logic                    wren;
  logic [DOUT_W*RATIO-1:0] din;
  logic                    rden;
  logic [DOUT_W-1:0]       dout;
  logic                    flush;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic                    overflow;
  logic                    underflow;
  logic [31:0]             dcnt;

  modport master (
    output wren, din, rden, flush,
    input  dout, full, empty,
    input  almost_full, almost_empty,
    input  overflow, underflow, dcnt
  );

  modport slave (
    input  wren, din, rden, flush,
    output dout, full, empty,
    output almost_full, almost_empty,
    output overflow, underflow, dcnt
  );

endinterface

// File: rtl/util_sdp_ram.sv
// Simple dual-port RAM: synchronous write,
// asynchronous read. Contents are never reset.
module util_sdp_ram #(
  parameter int W     = 128,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/util_wconv_fifo.sv
// Wide-in / narrow-out FIFO: each stored word
// is read back as RATIO lanes of DOUT_W bits.
module util_wconv_fifo
  import util_fifo_pkg::*;
#(
  parameter int DOUT_W     = 32,
  parameter int RATIO      = 4,
  parameter int DEPTH      = 16,
  parameter int LANE_ORDER = LANE_LSB_FIRST,
  parameter int AF_LVL     = DEPTH - 2,
  parameter int AE_LVL     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wren,
  input  logic [DOUT_W*RATIO-1:0] din,
  input  logic                    rden,
  output logic [DOUT_W-1:0]       dout,
  input  logic                    flush,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    overflow,
  output logic                    underflow,
  output logic [31:0]             dcnt
);

  localparam int DIN_W = DOUT_W * RATIO;
  localparam int AW    = clog2(DEPTH);
  localparam int LW    = (RATIO > 1) ? clog2(RATIO) : 1;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     lane;
  logic [LW-1:0]     lane_nxt;
  logic [LW-1:0]     sel;
  logic [AW:0]       entries;
  logic [AW:0]       ent_nxt;
  logic [31:0]       dcnt_q;
  logic [31:0]       dcnt_nxt;
  logic [DIN_W-1:0]  rdata;
  logic [DOUT_W-1:0] lane_data;
  logic              wr_acc;
  logic              rd_acc;
  logic              last;
  logic              rel;

  assign full         = entries == (AW+1)'(DEPTH);
  assign empty        = dcnt_q == '0;
  assign almost_full  = 32'(entries) >= 32'(AF_LVL);
  assign almost_empty = dcnt_q <= 32'(AE_LVL);
  assign dcnt         = dcnt_q;

  assign wr_acc = wren & ~full;
  assign rd_acc = rden & ~empty;
  assign last   = lane == LW'(RATIO - 1);
  assign rel    = rd_acc & last;

  assign sel = (LANE_ORDER == LANE_MSB_FIRST)
             ? LW'(RATIO - 1) - lane
             : lane;

  // dcnt is precomputed so it lands with the flags
  always_comb begin
    lane_nxt = lane;
    if (rd_acc) lane_nxt = last ? '0 : lane + 1'b1;
    ent_nxt  = entries
             + (AW+1)'(wr_acc)
             - (AW+1)'(rel);
    dcnt_nxt = 32'(ent_nxt) * 32'(RATIO)
             - 32'(lane_nxt);
  end

  always_comb begin
    lane_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (sel == LW'(k))
        lane_data = rdata[k*DOUT_W +: DOUT_W];
    end
  end

  util_sdp_ram #(
    .W     (DIN_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & rst_n & ~flush),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      lane      <= '0;
      entries   <= '0;
      dcnt_q    <= '0;
      dout      <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rel)    rd_ptr <= rd_ptr + 1'b1;
      if (rd_acc) dout   <= lane_data;
      lane    <= lane_nxt;
      entries <= ent_nxt;
      dcnt_q  <= dcnt_nxt;
      if (wren & full)  overflow  <= 1'b1;
      if (rden & empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_util_wconv_fifo.sv
// Directed bench for util_wconv_fifo; read data
// is checked by per-DUT scoreboard monitors.
module tb_util_wconv_fifo;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  always #5 clk = ~clk;

  util_wconv_fifo_if #(.DOUT_W(32), .RATIO(4)) ia ();
  util_wconv_fifo_if #(.DOUT_W(32), .RATIO(4)) ib ();

  util_wconv_fifo #(
    .LANE_ORDER (0)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .wren         (ia.wren),
    .din          (ia.din),
    .rden         (ia.rden),
    .dout         (ia.dout),
    .flush        (ia.flush),
    .full         (ia.full),
    .empty        (ia.empty),
    .almost_full  (ia.almost_full),
    .almost_empty (ia.almost_empty),
    .overflow     (ia.overflow),
    .underflow    (ia.underflow),
    .dcnt         (ia.dcnt)
  );

  util_wconv_fifo #(
    .LANE_ORDER (1)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .wren         (ib.wren),
    .din          (ib.din),
    .rden         (ib.rden),
    .dout         (ib.dout),
    .flush        (ib.flush),
    .full         (ib.full),
    .empty        (ib.empty),
    .almost_full  (ib.almost_full),
    .almost_empty (ib.almost_empty),
    .overflow     (ib.overflow),
    .underflow    (ib.underflow),
    .dcnt         (ib.dcnt)
  );

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [127:0] d,
                     input logic r, input logic f);
    ia.wren  = w;
    ia.din   = d;
    ia.rden  = r;
    ia.flush = f;
    @(negedge clk);
  endtask

  task automatic wr_a(input logic [127:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd_a(input logic [31:0] e);
    qa.push_back(e);
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  always @(posedge clk) begin
    logic [31:0] e;
    if (rst_n && !ia.flush && ia.rden && !ia.empty) begin
      #1;
      checks++;
      if (qa.size() == 0) begin
        failures++;
        $display("FAIL rd_a extra read got=%h want=none", ia.dout);
      end else begin
        e = qa.pop_front();
        if (ia.dout !== e) begin
          failures++;
          $display("FAIL rd_a dout got=%h want=%h", ia.dout, e);
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] e;
    if (rst_n && !ib.flush && ib.rden && !ib.empty) begin
      #1;
      checks++;
      if (qb.size() == 0) begin
        failures++;
        $display("FAIL rd_b extra read got=%h want=none", ib.dout);
      end else begin
        e = qb.pop_front();
        if (ib.dout !== e) begin
          failures++;
          $display("FAIL rd_b dout got=%h want=%h", ib.dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    ia.wren = 0; ia.din = '0; ia.rden = 0; ia.flush = 0;
    ib.wren = 0; ib.din = '0; ib.rden = 0; ib.flush = 0;
    repeat (2) @(negedge clk);

    chk("rst_empty", 32'(ia.empty), 32'd1);
    chk("rst_full", 32'(ia.full), 32'd0);
    chk("rst_af", 32'(ia.almost_full), 32'd0);
    chk("rst_ae", 32'(ia.almost_empty), 32'd1);
    chk("rst_dcnt", ia.dcnt, 32'd0);
    chk("rst_dout", ia.dout, 32'd0);
    chk("rst_ovf", 32'(ia.overflow), 32'd0);
    chk("rst_unf", 32'(ia.underflow), 32'd0);
    rst_n = 1'b1;

    // one word in, four lanes out
    wr_a(mk(32'd1));
    chk("w1_dcnt", ia.dcnt, 32'd4);
    chk("w1_empty", 32'(ia.empty), 32'd0);
    rd_a(32'd1);
    chk("r1_dcnt", ia.dcnt, 32'd3);
    chk("r1_ae", 32'(ia.almost_empty), 32'd0);
    rd_a(32'd2);
    chk("r2_dcnt", ia.dcnt, 32'd2);
    chk("r2_ae", 32'(ia.almost_empty), 32'd1);
    rd_a(32'd3);
    chk("r3_dcnt", ia.dcnt, 32'd1);
    rd_a(32'd4);
    chk("r4_dcnt", ia.dcnt, 32'd0);
    chk("r4_empty", 32'(ia.empty), 32'd1);
    cyc(0, '0, 0, 0);

    // fill to full
    for (int i = 0; i < 16; i++) begin
      wr_a(mk(32'(256 + 4 * i)));
      if (i == 12) chk("af_13", 32'(ia.almost_full), 32'd0);
      if (i == 13) chk("af_14", 32'(ia.almost_full), 32'd1);
    end
    chk("fill_full", 32'(ia.full), 32'd1);
    chk("fill_dcnt", ia.dcnt, 32'd64);
    wr_a(mk(32'hDEAD_0000));
    chk("ovf_set", 32'(ia.overflow), 32'd1);
    chk("ovf_dcnt", ia.dcnt, 32'd64);

    // wren+rden held while full
    for (int k = 0; k < 4; k++) begin
      qa.push_back(32'(256 + k));
      cyc(1, mk(32'hAAAA_0000), 1, 0);
      if (k == 0) chk("rw_drop_dcnt", ia.dcnt, 32'd63);
    end
    chk("rw_full_fall", 32'(ia.full), 32'd0);
    chk("rw_rel_dcnt", ia.dcnt, 32'd60);
    qa.push_back(32'd260);
    cyc(1, mk(32'hAAAA_0000), 1, 0);
    chk("rw_acc_dcnt", ia.dcnt, 32'd63);
    chk("rw_acc_full", 32'(ia.full), 32'd1);

    for (int k = 1; k < 4; k++) rd_a(32'(260 + k));
    for (int i = 2; i < 16; i++)
      for (int k = 0; k < 4; k++) rd_a(32'(256 + 4 * i + k));
    for (int k = 0; k < 4; k++) rd_a(32'hAAAA_0000 + 32'(k));
    chk("drain_empty", 32'(ia.empty), 32'd1);
    chk("drain_dcnt", ia.dcnt, 32'd0);
    chk("ovf_sticky", 32'(ia.overflow), 32'd1);

    // underflow then flush
    cyc(0, '0, 1, 0);
    chk("unf_set", 32'(ia.underflow), 32'd1);
    chk("unf_dout", ia.dout, 32'hAAAA_0003);
    chk("unf_dcnt", ia.dcnt, 32'd0);
    cyc(0, '0, 0, 1);
    chk("fl_unf", 32'(ia.underflow), 32'd0);
    chk("fl_ovf", 32'(ia.overflow), 32'd0);
    chk("fl_dout", ia.dout, 32'd0);
    chk("fl_ae", 32'(ia.almost_empty), 32'd1);

    // MSB-first lane order
    ib.wren = 1; ib.din = mk(32'd1);
    @(negedge clk);
    ib.wren = 0; ib.rden = 1;
    for (int k = 0; k < 4; k++) begin
      qb.push_back(32'(4 - k));
      @(negedge clk);
    end
    ib.rden = 0;
    chk("b_empty", 32'(ib.empty), 32'd1);

    // flush mid-stream, flush beats wren/rden
    for (int j = 0; j < 5; j++) wr_a(mk(32'h5000_0000 + 32'(4 * j)));
    rd_a(32'h5000_0000);
    rd_a(32'h5000_0001);
    cyc(1, mk(32'h7777_0000), 1, 1);
    chk("fl2_dcnt", ia.dcnt, 32'd0);
    chk("fl2_empty", 32'(ia.empty), 32'd1);
    wr_a(mk(32'hCCCC_0000));
    chk("fl2_new_dcnt", ia.dcnt, 32'd4);
    rd_a(32'hCCCC_0000);
    cyc(0, '0, 0, 1);

    // reset mid-stream
    for (int j = 0; j < 5; j++) wr_a(mk(32'h6000_0000 + 32'(4 * j)));
    rd_a(32'h6000_0000);
    rd_a(32'h6000_0001);
    rst_n = 1'b0;
    cyc(0, '0, 0, 0);
    rst_n = 1'b1;
    chk("rs2_dcnt", ia.dcnt, 32'd0);
    chk("rs2_empty", 32'(ia.empty), 32'd1);
    chk("rs2_dout", ia.dout, 32'd0);
    wr_a(mk(32'hBBBB_0000));
    rd_a(32'hBBBB_0000);
    cyc(0, '0, 0, 0);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d,%0d want=0,0",
               qa.size(), qb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/util_wconv_fifo.md
UTIL_WCONV_FIFO -- requirements
Module: util_wconv_fifo

Interface
REQ-001 SHALL have parameter DOUT_W, default 32: output word width in bits.
REQ-002 SHALL have parameter RATIO, default 4: output words per input word; power of two, 1..16.
REQ-003 SHALL have parameter DEPTH, default 16: storage in input words; power of two, at least 2.
REQ-004 SHALL have parameter LANE_ORDER, default 0: 0 = LSB lane read first, 1 = MSB lane read first.
REQ-005 SHALL have parameter AF_LVL, default DEPTH-2: almost_full threshold, in input words.
REQ-006 SHALL have parameter AE_LVL, default 2: almost_empty threshold, in output words.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 SHALL have port wren, input, 1 bit: write request.
REQ-010 SHALL have port din, input, DOUT_W*RATIO bits: write data.
REQ-011 SHALL have port rden, input, 1 bit: read request.
REQ-012 SHALL have port dout, output, DOUT_W bits: registered read data.
REQ-013 SHALL have port flush, input, 1 bit: synchronous clear of contents.
REQ-014 SHALL have outputs full, empty, almost_full and almost_empty, 1 bit each: status flags.
REQ-015 SHALL have outputs overflow and underflow, 1 bit each: sticky error flags.
REQ-016 SHALL have output dcnt, 32 bits: output words available, zero-extended.

Function
REQ-017 SHALL accept a write on an edge when wren=1 and full=0; the flag is sampled before the edge, so a write while full is dropped even if a same-cycle read frees an entry.
REQ-018 SHALL accept a read on an edge when rden=1 and empty=0; dout SHALL load the selected lane on that edge (1-cycle latency) and SHALL hold its value otherwise.
REQ-019 SHALL track the lane index 0..RATIO-1 within the head entry; each accepted read advances it.
REQ-020 SHALL, on a read of lane RATIO-1, reset the lane index to 0, advance the read pointer and release the entry.
REQ-021 SHALL, with LANE_ORDER=0, return din[DOUT_W*(k+1)-1 : DOUT_W*k] for lane k; with LANE_ORDER=1, it SHALL return lane RATIO-1-k.
REQ-022 SHALL compute entries = writes accepted minus entries released, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-023 SHALL drive dcnt = entries*RATIO - lane_index, registered and consistent with the flags in the same cycle.
REQ-024 SHALL assert full when entries=DEPTH, empty when dcnt=0, almost_full when entries>=AF_LVL, and almost_empty when dcnt<=AE_LVL.
REQ-025 SHALL allow a simultaneous accepted read and write: entries changes by +1, 0 or -1 as defined in REQ-020/022.
REQ-026 SHALL set overflow on a write request while full, and underflow on a read request while empty; each flag holds until reset or flush; the rejected request SHALL have no other effect.
REQ-027 SHALL, when flush=1, take priority over wren and rden in the same cycle, zero the pointers, lane index, entries, dcnt, dout, overflow and underflow, and set empty=1 and almost_empty=1.
REQ-028 SHALL, with RATIO=1, behave as a plain synchronous FIFO of width DOUT_W.

Reset
REQ-029 SHALL, on an edge with rst_n=0, produce the same state as flush; full=0, almost_full=0, dout=0, dcnt=0.
REQ-030 SHALL abandon any in-flight data when reset is applied mid-operation, with no stale reads after release.
REQ-031 SHALL leave the storage array contents unreset.

Structure
REQ-032 SHALL place the clog2 function and the LANE_LSB_FIRST/LANE_MSB_FIRST constants in the shared package util_fifo_pkg.
REQ-033 SHALL implement storage as sub-module util_sdp_ram (write port plus asynchronous read port); the lane multiplexer and dout register SHALL sit in util_wconv_fifo.

Verification (defaults unless stated)
REQ-034 SHALL cover: after reset, write one word 0x00000004_00000003_00000002_00000001, then read 4 -> dout=1,2,3,4 on successive cycles; empty=1 after the 4th read; dcnt 4->0.
REQ-035 SHALL cover: write 16 words with no reads -> full=1 and dcnt=64 after the 16th; a 17th write -> overflow=1, dcnt stays 64; reading 64 words returns data in order with no loss.
REQ-036 SHALL cover: with full=1, hold wren and rden asserted together -> writes are dropped until the 4th read releases an entry; full falls, and the next write is accepted.
REQ-037 SHALL cover: rden while empty -> underflow=1, dout unchanged, dcnt=0; a subsequent flush -> underflow=0.
REQ-038 SHALL cover: LANE_ORDER=1, write the REQ-034 word -> dout=4,3,2,1.
REQ-039 SHALL cover: flush or rst_n=0 asserted after 5 writes and 2 reads -> next cycle dcnt=0, empty=1; a new write then read returns the new data, lane 0 first.
